// File: rtl/cache_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// cache_ctrl_fsm
//   Control FSM for a 2-way set-associative, write-back / write-allocate L1
//   cache. It sequences hit, writeback and fill, drives every array load and
//   select, keeps the per-set 1-bit LRU up to date and counts hits, misses and
//   writebacks in saturating counters.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   mem_read, mem_write       CPU request, held until mem_resp (write wins)
//   mem_resp                  one-cycle completion pulse to the CPU
//   pmem_read, pmem_write     fill / writeback request, held until pmem_resp
//   pmem_resp                 physical memory done, one cycle
//   cache_hit, way_hit        tag match and matching way for the current index
//   lru_out                   LRU bit of the current set (way to evict)
//   valid_out, dirty_out      [way1:way0] status bits of the current set
//   tag_ld                    per-way tag load
//   valid_ld, valid_in        per-way valid load and value
//   dirty_ld, dirty_in        per-way dirty load and value
//   lru_ld, lru_in            LRU load and new LRU value
//   wen_sel[way]              0 no write, 1 write whole line, 2 masked write
//   wdata_sel[way]            0 cacheline_in, 1 bus write data
//   output_sel                way driven onto cacheline_out / CPU read data
//   pmem_addr_sel             0 CPU address, 1 victim address
//   hit_cnt, miss_cnt, wb_cnt saturating event counters
// ----------------------------------------------------------------------------
module cache_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             cache_hit,
  input  logic             way_hit,
  input  logic             lru_out,
  input  logic [1:0]       valid_out,
  input  logic [1:0]       dirty_out,
  output logic [1:0]       tag_ld,
  output logic [1:0]       valid_ld,
  output logic [1:0]       valid_in,
  output logic [1:0]       dirty_ld,
  output logic [1:0]       dirty_in,
  output logic             lru_ld,
  output logic             lru_in,
  output logic [1:0][1:0]  wen_sel,
  output logic [1:0]       wdata_sel,
  output logic             output_sel,
  output logic             pmem_addr_sel,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WB,
    FILL
  } state_e;

  typedef enum logic [1:0] {
    WEN_NONE   = 2'd0,
    WEN_ALL    = 2'd1,
    WEN_MASKED = 2'd2
  } wen_e;

  state_e           state_q, state_d;
  logic             victim_q, victim_d;
  // Set once a fill has completed for the current request, so the
  // re-CHECK that follows is never counted as a second miss.
  logic             refill_q, refill_d;
  logic             hit_inc, miss_inc, wb_inc;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      victim_q   <= 1'b0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
      if (hit_inc && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (miss_inc && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
      if (wb_inc && (wb_cnt_q != '1)) begin
        wb_cnt_q <= wb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    refill_d      = refill_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    tag_ld        = '0;
    valid_ld      = '0;
    valid_in      = '0;
    dirty_ld      = '0;
    dirty_in      = '0;
    lru_ld        = 1'b0;
    lru_in        = 1'b0;
    wen_sel       = '0;
    wdata_sel     = '0;
    output_sel    = 1'b0;
    pmem_addr_sel = 1'b0;

    unique case (state_q)
      IDLE: begin
        refill_d = 1'b0;
        if (mem_read || mem_write) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (!(mem_read || mem_write)) begin
          // Request withdrawn: nothing to complete, return quietly.
          state_d  = IDLE;
          refill_d = 1'b0;
        end else if (cache_hit) begin
          mem_resp = 1'b1;
          lru_ld   = 1'b1;
          lru_in   = ~way_hit;
          hit_inc  = 1'b1;
          state_d  = IDLE;
          refill_d = 1'b0;
          if (mem_write) begin
            wen_sel[way_hit]   = WEN_MASKED;
            wdata_sel[way_hit] = 1'b1;
            dirty_ld[way_hit]  = 1'b1;
            dirty_in[way_hit]  = 1'b1;
          end else begin
            output_sel = way_hit;
          end
        end else begin
          victim_d = lru_out;
          miss_inc = ~refill_q;
          if (valid_out[lru_out] && dirty_out[lru_out]) begin
            state_d = WB;
          end else begin
            state_d = FILL;
          end
        end
      end

      WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        output_sel    = victim_q;
        if (pmem_resp) begin
          dirty_ld[victim_q] = 1'b1;
          wb_inc             = 1'b1;
          state_d            = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          wen_sel[victim_q]  = WEN_ALL;
          tag_ld[victim_q]   = 1'b1;
          valid_ld[victim_q] = 1'b1;
          valid_in[victim_q] = 1'b1;
          dirty_ld[victim_q] = 1'b1;
          state_d            = CHECK;
          refill_d           = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_cache_ctrl_fsm
//   Cycle-level vector bench for cache_ctrl_fsm with 4-bit counters. Each row
//   gives the inputs for one cycle plus the expected outputs and counter values
//   seen during that cycle; the status inputs stand in for the cache arrays.
// ----------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             mem_read, mem_write, mem_resp;
  logic             pmem_read, pmem_write, pmem_resp;
  logic             cache_hit, way_hit, lru_out;
  logic [1:0]       valid_out, dirty_out;
  logic [1:0]       tag_ld, valid_ld, valid_in, dirty_ld, dirty_in;
  logic             lru_ld, lru_in;
  logic [1:0][1:0]  wen_sel;
  logic [1:0]       wdata_sel;
  logic             output_sel, pmem_addr_sel;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

  cache_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .cache_hit(cache_hit), .way_hit(way_hit), .lru_out(lru_out),
    .valid_out(valid_out), .dirty_out(dirty_out),
    .tag_ld(tag_ld), .valid_ld(valid_ld), .valid_in(valid_in),
    .dirty_ld(dirty_ld), .dirty_in(dirty_in),
    .lru_ld(lru_ld), .lru_in(lru_in),
    .wen_sel(wen_sel), .wdata_sel(wdata_sel),
    .output_sel(output_sel), .pmem_addr_sel(pmem_addr_sel),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, rd, wr, pr, hit, wh, lru;
    logic [1:0] val, dty;
  } in_t;

  typedef struct packed {
    logic       resp, prd, pwr, asel, osel, lld, lin;
    logic [1:0] tld, vld, vin, dld, din;
    logic [3:0] wen;
    logic [1:0] wds;
  } out_t;

  typedef struct packed {
    logic [CNT_W-1:0] h, m, w;
  } cnt_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
    cnt_t  c;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic in_t I(logic rd, logic wr, logic pr, logic hit, logic wh,
                            logic lru, logic [1:0] val, logic [1:0] dty);
    return {1'b0, rd, wr, pr, hit, wh, lru, val, dty};
  endfunction

  function automatic out_t O(logic resp, logic prd, logic pwr, logic asel,
                             logic osel, logic lld, logic lin, logic [1:0] tld,
                             logic [1:0] vld, logic [1:0] vin, logic [1:0] dld,
                             logic [1:0] din, logic [3:0] wen, logic [1:0] wds);
    return {resp, prd, pwr, asel, osel, lld, lin, tld, vld, vin, dld, din, wen, wds};
  endfunction

  function automatic logic [1:0] oh(logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  function automatic out_t o_rd_hit(logic w);
    return O(1, 0, 0, 0, w, 1, !w, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00);
  endfunction

  function automatic out_t o_wr_hit(logic w);
    return O(1, 0, 0, 0, 0, 1, !w, 2'b00, 2'b00, 2'b00, oh(w), oh(w),
             w ? 4'b1000 : 4'b0010, oh(w));
  endfunction

  function automatic out_t o_wb(logic w, logic r);
    return O(0, 0, 1, 1, w, 0, 0, 2'b00, 2'b00, 2'b00, r ? oh(w) : 2'b00, 2'b00,
             4'b0000, 2'b00);
  endfunction

  function automatic out_t o_fill(logic w, logic r);
    logic [1:0] l;
    l = r ? oh(w) : 2'b00;
    return O(0, 1, 0, 0, 0, 0, 0, l, l, l, l, 2'b00,
             r ? (w ? 4'b0100 : 4'b0001) : 4'b0000, 2'b00);
  endfunction

  function automatic void add(string name, in_t i, out_t o, int h, int m, int w);
    vec_t v;
    v.name = name;
    v.i    = i;
    v.o    = o;
    v.c    = {CNT_W'(h), CNT_W'(m), CNT_W'(w)};
    vt.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    out_t act;
    cnt_t act_c;
    @(negedge clk);
    rst       = v.i.rst;
    mem_read  = v.i.rd;
    mem_write = v.i.wr;
    pmem_resp = v.i.pr;
    cache_hit = v.i.hit;
    way_hit   = v.i.wh;
    lru_out   = v.i.lru;
    valid_out = v.i.val;
    dirty_out = v.i.dty;
    sb.push_back(v);
    #1;
    e     = sb.pop_front();
    act   = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, output_sel, lru_ld,
             lru_in, tag_ld, valid_ld, valid_in, dirty_ld, dirty_in, wen_sel, wdata_sel};
    act_c = {hit_cnt, miss_cnt, wb_cnt};
    n_total++;
    if (act === e.o) n_pass++;
    else $display("FAIL %s outputs: got %h expected %h", e.name, act, e.o);
    n_total++;
    if (act_c === e.c) n_pass++;
    else $display("FAIL %s counters(hit,miss,wb): got %h expected %h", e.name, act_c, e.c);
    n_total++;
    if (!(pmem_read && pmem_write)) n_pass++;
    else $display("FAIL %s pmem overlap: got rd=1 wr=1 expected not both", e.name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {mem_read, mem_write, pmem_resp, cache_hit, way_hit, lru_out} = '0;
    valid_out = '0;
    dirty_out = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    in_t ri;
    out_t z;
    z = '0;

    // Reset state, then cold read of idx3: miss, fill way0, re-check hits.
    add("rst_idle",   I(0,0,0,0,0,0,2'b00,2'b00), z, 0, 0, 0);
    add("t1_req",     I(1,0,0,0,0,0,2'b00,2'b00), z, 0, 0, 0);
    add("t1_miss",    I(1,0,0,0,0,0,2'b00,2'b00), z, 0, 0, 0);
    add("t1_fill",    I(1,0,0,0,0,0,2'b00,2'b00), o_fill(0,0), 0, 1, 0);
    add("t1_fill_r",  I(1,0,1,0,0,0,2'b00,2'b00), o_fill(0,1), 0, 1, 0);
    add("t1_hit",     I(1,0,0,1,0,0,2'b01,2'b00), o_rd_hit(0), 0, 1, 0);
    add("t1_idle",    I(0,0,0,0,0,0,2'b01,2'b00), z, 1, 1, 0);
    // Read hit way0: response on the second request cycle.
    add("t2_req",     I(1,0,0,0,0,0,2'b01,2'b00), z, 1, 1, 0);
    add("t2_hit",     I(1,0,0,1,0,0,2'b01,2'b00), o_rd_hit(0), 1, 1, 0);
    add("t2_idle",    I(0,0,0,0,0,0,2'b01,2'b00), z, 2, 1, 0);
    // Write hit way1.
    add("t3_req",     I(0,1,0,0,0,0,2'b11,2'b00), z, 2, 1, 0);
    add("t3_hit",     I(0,1,0,1,1,0,2'b11,2'b00), o_wr_hit(1), 2, 1, 0);
    add("t3_idle",    I(0,0,0,0,0,0,2'b11,2'b10), z, 3, 1, 0);
    // Miss evicting dirty way1: five WB cycles, three FILL cycles, hit.
    add("t4_req",     I(1,0,0,0,0,1,2'b11,2'b10), z, 3, 1, 0);
    add("t4_miss",    I(1,0,0,0,0,1,2'b11,2'b10), z, 3, 1, 0);
    for (int k = 0; k < 4; k++)
      add("t4_wb",    I(1,0,0,0,0,1,2'b11,2'b10), o_wb(1,0), 3, 2, 0);
    add("t4_wb_r",    I(1,0,1,0,0,1,2'b11,2'b10), o_wb(1,1), 3, 2, 0);
    add("t4_fill",    I(1,0,0,0,0,1,2'b11,2'b00), o_fill(1,0), 3, 2, 1);
    add("t4_fill",    I(1,0,0,0,0,1,2'b11,2'b00), o_fill(1,0), 3, 2, 1);
    add("t4_fill_r",  I(1,0,1,0,0,1,2'b11,2'b00), o_fill(1,1), 3, 2, 1);
    add("t4_hit",     I(1,0,0,1,1,1,2'b11,2'b00), o_rd_hit(1), 3, 2, 1);
    add("t4_idle",    I(0,0,0,0,0,0,2'b11,2'b00), z, 4, 2, 1);
    // Read and write together: write wins.
    add("pri_req",    I(1,1,0,0,0,0,2'b11,2'b00), z, 4, 2, 1);
    add("pri_hit",    I(1,1,0,1,0,0,2'b11,2'b00), o_wr_hit(0), 4, 2, 1);
    add("pri_idle",   I(0,0,0,0,0,0,2'b11,2'b01), z, 5, 2, 1);
    // Write miss, victim way0 clean while way1 is dirty: no writeback.
    add("cln_req",    I(0,1,0,0,0,0,2'b11,2'b10), z, 5, 2, 1);
    add("cln_miss",   I(0,1,0,0,0,0,2'b11,2'b10), z, 5, 2, 1);
    add("cln_fill_r", I(0,1,1,0,0,0,2'b11,2'b10), o_fill(0,1), 5, 3, 1);
    add("cln_hit",    I(0,1,0,1,0,0,2'b11,2'b10), o_wr_hit(0), 5, 3, 1);
    add("cln_idle",   I(0,0,0,0,0,0,2'b11,2'b11), z, 6, 3, 1);
    // Reset two cycles into FILL, then the same read misses again.
    add("t5_req",     I(1,0,0,0,0,0,2'b00,2'b00), z, 6, 3, 1);
    add("t5_miss",    I(1,0,0,0,0,0,2'b00,2'b00), z, 6, 3, 1);
    add("t5_fill",    I(1,0,0,0,0,0,2'b00,2'b00), o_fill(0,0), 6, 4, 1);
    ri = I(1,0,0,0,0,0,2'b00,2'b00);
    ri.rst = 1'b1;
    add("t5_fill_rst", ri, o_fill(0,0), 6, 4, 1);
    add("t5_after",   I(0,0,0,0,0,0,2'b00,2'b00), z, 0, 0, 0);
    add("t5_req2",    I(1,0,0,0,0,0,2'b00,2'b00), z, 0, 0, 0);
    add("t5_miss2",   I(1,0,0,0,0,0,2'b00,2'b00), z, 0, 0, 0);
    add("t5_fill2_r", I(1,0,1,0,0,0,2'b00,2'b00), o_fill(0,1), 0, 1, 0);
    add("t5_hit2",    I(1,0,0,1,0,0,2'b01,2'b00), o_rd_hit(0), 0, 1, 0);
    add("t5_idle",    I(0,0,0,0,0,0,2'b01,2'b00), z, 1, 1, 0);

    do_reset();
    foreach (vt[k]) apply(vt[k]);

    // Hit counter saturation: 16 read hits on way1, counter holds at 15.
    do_reset();
    vt.delete();
    for (int k = 0; k < 16; k++) begin
      add("sat_req", I(1,0,0,0,0,0,2'b11,2'b00), z, (k > 15) ? 15 : k, 0, 0);
      add("sat_hit", I(1,0,0,1,1,0,2'b11,2'b00), o_rd_hit(1), (k > 15) ? 15 : k, 0, 0);
    end
    add("sat_end", I(0,0,0,0,0,0,2'b11,2'b00), z, 15, 0, 0);
    add("sat_hold", I(1,0,0,0,0,0,2'b11,2'b00), z, 15, 0, 0);
    add("sat_hit17", I(1,0,0,1,0,0,2'b11,2'b00), o_rd_hit(0), 15, 0, 0);
    add("sat_final", I(0,0,0,0,0,0,2'b11,2'b00), z, 15, 0, 0);
    foreach (vt[k]) apply(vt[k]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
